mem_arbiter: RTL and testbench

Sequences and shares the single byte-wide external memory bus between the instruction-fetch requester and the load/store (MEM-stage) requester. It turns 1/2/4-byte requests into byte transfers, assembles and splits little-endian words, throttles UART writes on `io_buffer_full`, and honours the `rdy_in` pause. It sits between the IF/MEM stages and the top-level `mem_din/mem_dout/mem_a/mem_wr` pins.

---
 rtl/mem_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter: shares the byte-wide external memory bus between instruction
// fetch and load/store, splitting 1/2/4-byte requests into byte transfers.
// Rev 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        rdy_in,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        inst_flush,
    output logic        inst_ack,
    output logic [31:0] inst_data,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_len,
    input  logic [31:0] data_wdata,
    output logic        data_ack,
    output logic [31:0] data_rdata,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INST   = 3'd1;
    localparam logic [2:0] S_DREAD  = 3'd2;
    localparam logic [2:0] S_DWRITE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] C_LIMIT  = 3'(STARVE_LIMIT);

    logic [2:0]  state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  iss_q, iss_d;
    logic [2:0]  cap_q, cap_d;
    logic        pend_q, pend_d;
    logic [2:0]  starve_q, starve_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic        inst_ack_q, inst_ack_d;
    logic        data_ack_q, data_ack_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic [7:0]  mem_dout_q;

    logic        w_active_rd;
    logic        w_more;
    logic        w_io_block;
    logic        w_abort;
    logic        w_inst_ok;
    logic [2:0]  w_len_data;
    logic [7:0]  w_wr_byte;

    assign w_active_rd = (state_q == S_INST) || (state_q == S_DREAD);
    assign w_more      = iss_q < len_q;
    assign w_abort     = (state_q == S_INST) && inst_flush;
    assign w_inst_ok   = inst_req && !inst_flush;
    assign w_wr_byte   = wbuf_q[{iss_q[1:0], 3'b000} +: 8];

    always_comb begin
        w_len_data = 3'd4;
        case (data_len)
            2'b00:   w_len_data = 3'd1;
            2'b01:   w_len_data = 3'd2;
            default: w_len_data = 3'd4;
        endcase
    end

    // Bus pins: address only while a byte remains to be issued, otherwise 0.
    always_comb begin
        mem_a = 32'd0;
        if ((w_active_rd || state_q == S_DWRITE) && w_more) begin
            mem_a = base_q + {29'd0, iss_q};
        end
    end

    // UART window sits at mem_a[17:16] == 2'b11.
    assign w_io_block = (mem_a[17:16] == 2'b11) && io_buffer_full;
    assign mem_wr     = (state_q == S_DWRITE) && w_more && rdy_in && !w_io_block;
    assign mem_dout   = ((state_q == S_DWRITE) && w_more) ? w_wr_byte : mem_dout_q;

    // A flush arriving in the ack cycle still hides the stale fetch word.
    assign inst_ack   = inst_ack_q && !inst_flush;
    assign data_ack   = data_ack_q;
    assign inst_data  = inst_data_q;
    assign data_rdata = data_rdata_q;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        iss_d        = iss_q;
        cap_d        = cap_q;
        pend_d       = pend_q;
        starve_d     = starve_q;
        wbuf_d       = wbuf_q;
        rbuf_d       = rbuf_q;
        inst_ack_d   = inst_ack_q;
        data_ack_d   = data_ack_q;
        inst_data_d  = inst_data_q;
        data_rdata_d = data_rdata_q;

        if (rdy_in && !inst_req) begin
            starve_d = 3'd0;
        end

        // A flush is honoured even while paused so that it is never lost.
        if (w_abort) begin
            state_d = S_IDLE;
            iss_d   = 3'd0;
            cap_d   = 3'd0;
            pend_d  = 1'b0;
        end else if (!rdy_in) begin
            pend_d = 1'b0;
            if (w_active_rd) begin
                iss_d = cap_q;
            end
        end else begin
            inst_ack_d = 1'b0;
            data_ack_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    iss_d  = 3'd0;
                    cap_d  = 3'd0;
                    pend_d = 1'b0;
                    rbuf_d = 32'd0;
                    if (w_inst_ok && (!data_req || starve_q == C_LIMIT)) begin
                        state_d  = S_INST;
                        base_d   = inst_addr;
                        len_d    = 3'd4;
                        starve_d = 3'd0;
                    end else if (data_req) begin
                        state_d = data_we ? S_DWRITE : S_DREAD;
                        base_d  = data_addr;
                        len_d   = w_len_data;
                        wbuf_d  = data_wdata;
                        if (inst_req && starve_q != C_LIMIT) begin
                            starve_d = starve_q + 3'd1;
                        end
                    end
                end
                S_INST, S_DREAD: begin
                    pend_d = w_more;
                    if (w_more) begin
                        iss_d = iss_q + 3'd1;
                    end
                    if (pend_q) begin
                        rbuf_d[{cap_q[1:0], 3'b000} +: 8] = mem_din;
                        cap_d = cap_q + 3'd1;
                        if (cap_d == len_q) begin
                            state_d = S_DONE;
                            pend_d  = 1'b0;
                            if (state_q == S_INST) begin
                                inst_ack_d  = 1'b1;
                                inst_data_d = rbuf_d;
                            end else begin
                                data_ack_d   = 1'b1;
                                data_rdata_d = rbuf_d;
                            end
                        end
                    end
                end
                S_DWRITE: begin
                    if (w_more && !w_io_block) begin
                        iss_d = iss_q + 3'd1;
                        if (iss_d == len_q) begin
                            state_d    = S_DONE;
                            data_ack_d = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q      <= S_IDLE;
            base_q       <= 32'd0;
            len_q        <= 3'd0;
            iss_q        <= 3'd0;
            cap_q        <= 3'd0;
            pend_q       <= 1'b0;
            starve_q     <= 3'd0;
            wbuf_q       <= 32'd0;
            rbuf_q       <= 32'd0;
            inst_ack_q   <= 1'b0;
            data_ack_q   <= 1'b0;
            inst_data_q  <= 32'd0;
            data_rdata_q <= 32'd0;
            mem_dout_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            iss_q        <= iss_d;
            cap_q        <= cap_d;
            pend_q       <= pend_d;
            starve_q     <= starve_d;
            wbuf_q       <= wbuf_d;
            rbuf_q       <= rbuf_d;
            inst_ack_q   <= inst_ack_d;
            data_ack_q   <= data_ack_d;
            inst_data_q  <= inst_data_d;
            data_rdata_q <= data_rdata_d;
            mem_dout_q   <= mem_dout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: directed vectors, hand-written corner sequences and random
// transactions against a transaction-level memory model.
module tb_mem_arbiter;

    localparam int LIMIT = 2;

    logic        clk_in = 1'b0;
    logic        rst_in_n = 1'b0;
    logic        rdy_in = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'd0;
    logic        inst_flush = 1'b0;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [31:0] data_addr = 32'd0;
    logic [1:0]  data_len = 2'd0;
    logic [31:0] data_wdata = 32'd0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din;
    logic        inst_ack, data_ack, mem_wr;
    logic [31:0] inst_data, data_rdata, mem_a;
    logic [7:0]  mem_dout;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_in(clk_in), .rst_in_n(rst_in_n), .rdy_in(rdy_in),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_flush(inst_flush),
        .inst_ack(inst_ack), .inst_data(inst_data),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_len(data_len), .data_wdata(data_wdata),
        .data_ack(data_ack), .data_rdata(data_rdata),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- memory models ----------------
    logic [7:0] mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 8'h13;
            32'h0000_0101: return 8'h05;
            32'h0000_0102: return 8'h10;
            32'h0000_0103: return 8'h00;
            32'h0000_2000: return 8'hFF;
            32'h0000_2001: return 8'h34;
            32'h0000_2002: return 8'h12;
            32'h0000_2003: return 8'h80;
            32'hFFFF_FFFE: return 8'hAA;
            32'hFFFF_FFFF: return 8'hBB;
            32'h0000_0000: return 8'h11;
            32'h0000_0001: return 8'h22;
            default:       return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [7:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    // Synchronous byte RAM: write on mem_wr, read data one cycle after address.
    always @(posedge clk_in) begin
        if (mem_wr) mem[mem_a] = mem_dout;
        mem_din <= rd_mem(mem_a);
    end

    // ---------------- checking helpers ----------------
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_in);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_in);
    endtask

    // One transaction from an IDLE cycle (cycle 0) until its ack; lat = ack cycle.
    task automatic run_txn(input int kind, input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] wdata, input bit rnd,
                           output int lat, output logic [31:0] rdata,
                           output bit wr_bad, output bit stalled);
        lat = -1; rdata = 32'd0; wr_bad = 1'b0; stalled = 1'b0;
        if (kind == 0) begin
            inst_req = 1'b1; inst_addr = addr;
        end else begin
            data_req = 1'b1; data_we = (kind == 2); data_addr = addr;
            data_len = len; data_wdata = wdata;
        end
        for (int c = 0; c < 40; c++) begin
            if (rnd && c > 0) begin
                rdy_in = ($urandom_range(0, 7) != 0);
                io_buffer_full = 1'($urandom_range(0, 1));
                if (!rdy_in) stalled = 1'b1;
            end
            smp();
            if (kind != 2 && mem_wr) wr_bad = 1'b1;
            if ((kind == 0 && inst_ack) || (kind != 0 && data_ack)) begin
                lat = c;
                rdata = (kind == 0) ? inst_data : data_rdata;
            end
            nxt();
            if (lat >= 0) break;
        end
        inst_req = 1'b0; data_req = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
        nxt(); nxt();
    endtask

    function automatic int nbytes(input int kind, input logic [1:0] len);
        if (kind == 0) return 4;
        case (len)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    typedef struct {
        int          kind;      // 0 fetch, 1 load, 2 store
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        int          exp_lat;
        logic [31:0] exp_data;
    } vec_t;

    function automatic vec_t mk(input int k, input logic [31:0] a, input logic [1:0] l,
                                input logic [31:0] w, input int el, input logic [31:0] ed);
        vec_t v;
        v.kind = k; v.addr = a; v.len = l; v.wdata = w; v.exp_lat = el; v.exp_data = ed;
        return v;
    endfunction

    vec_t        vt[13];
    int          lat, kind, n, ng, cnt;
    int          got[6];
    int          exp_ord[6];
    logic [31:0] addr, wdata, rdata, expd;
    logic [1:0]  len;
    bit          rnd, wr_bad, stalled, wr_seen, ack_seen;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = mk(0, 32'h0000_0100, 2'b10, 32'h0,         6, 32'h0010_0513);
        vt[1]  = mk(1, 32'h0000_2000, 2'b00, 32'h0,         3, 32'h0000_00FF);
        vt[2]  = mk(1, 32'h0000_2000, 2'b01, 32'h0,         4, 32'h0000_34FF);
        vt[3]  = mk(1, 32'h0000_2000, 2'b10, 32'h0,         6, 32'h8012_34FF);
        vt[4]  = mk(1, 32'h0000_2000, 2'b11, 32'h0,         6, 32'h8012_34FF);
        vt[5]  = mk(2, 32'h0000_4000, 2'b10, 32'hCAFE_BABE, 5, 32'h0);
        vt[6]  = mk(1, 32'h0000_4000, 2'b10, 32'h0,         6, 32'hCAFE_BABE);
        vt[7]  = mk(2, 32'h0000_4001, 2'b00, 32'h0000_0077, 2, 32'h0);
        vt[8]  = mk(1, 32'h0000_4000, 2'b10, 32'h0,         6, 32'hCAFE_77BE);
        vt[9]  = mk(1, 32'h0000_4002, 2'b01, 32'h0,         4, 32'h0000_CAFE);
        vt[10] = mk(1, 32'hFFFF_FFFE, 2'b10, 32'h0,         6, 32'h2211_BBAA);
        vt[11] = mk(2, 32'hFFFF_FFFF, 2'b01, 32'h0000_5566, 3, 32'h0);
        vt[12] = mk(1, 32'hFFFF_FFFE, 2'b10, 32'h0,         6, 32'h2255_66AA);

        // ---------------- reset state ----------------
        nxt(); nxt();
        smp();
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'h0);
        chk("rst_acks", {30'd0, inst_ack, data_ack}, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_data_rdata", data_rdata, 32'h0);
        nxt();
        rst_in_n = 1'b1;
        nxt();

        // ---------------- table-driven vectors ----------------
        foreach (vt[i]) begin
            run_txn(vt[i].kind, vt[i].addr, vt[i].len, vt[i].wdata, 1'b0,
                    lat, rdata, wr_bad, stalled);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
            if (vt[i].kind != 2) begin
                chk($sformatf("vec%0d_data", i), rdata, vt[i].exp_data);
                chk($sformatf("vec%0d_no_write", i), {31'd0, wr_bad}, 32'h0);
            end
        end

        // ---------------- fetch bus addresses ----------------
        inst_req = 1'b1; inst_addr = 32'h100;
        for (int c = 0; c <= 6; c++) begin
            smp();
            if (c >= 1 && c <= 4) chk($sformatf("fetch_addr_c%0d", c), mem_a, 32'h100 + 32'(c - 1));
            if (c == 6) begin
                chk("fetch_ack_c6", {31'd0, inst_ack}, 32'h1);
                chk("fetch_word", inst_data, 32'h0010_0513);
            end
            nxt();
        end
        inst_req = 1'b0;
        nxt();

        // ---------------- simultaneous requests: data first ----------------
        inst_req = 1'b1; inst_addr = 32'h100;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h2000; data_len = 2'b00;
        for (int c = 0; c <= 10; c++) begin
            smp();
            if (c == 1) chk("both_first_addr", mem_a, 32'h2000);
            if (c == 3) begin
                chk("both_data_ack_c3", {31'd0, data_ack}, 32'h1);
                chk("both_data_byte", data_rdata, 32'h0000_00FF);
            end
            if (c == 5) chk("both_fetch_addr_c5", mem_a, 32'h100);
            if (c == 10) begin
                chk("both_inst_ack_c10", {31'd0, inst_ack}, 32'h1);
                chk("both_inst_word", inst_data, 32'h0010_0513);
            end
            nxt();
            if (c == 3) data_req = 1'b0;
        end
        inst_req = 1'b0;
        nxt();

        // ---------------- half store throttled by io_buffer_full ----------------
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0003_0000; data_len = 2'b01;
        data_wdata = 32'h0000_BEEF;
        for (int c = 0; c <= 6; c++) begin
            io_buffer_full = (c >= 1 && c <= 3);
            smp();
            if (c >= 1 && c <= 3) chk($sformatf("io_hold_wr_c%0d", c), {31'd0, mem_wr}, 32'h0);
            if (c == 4) begin
                chk("io_wr_c4", {31'd0, mem_wr}, 32'h1);
                chk("io_addr_c4", mem_a, 32'h0003_0000);
                chk("io_dout_c4", {24'd0, mem_dout}, 32'hEF);
            end
            if (c == 5) begin
                chk("io_wr_c5", {31'd0, mem_wr}, 32'h1);
                chk("io_addr_c5", mem_a, 32'h0003_0001);
                chk("io_dout_c5", {24'd0, mem_dout}, 32'hBE);
            end
            if (c == 6) chk("io_ack_c6", {31'd0, data_ack}, 32'h1);
            nxt();
        end
        data_req = 1'b0; data_we = 1'b0; io_buffer_full = 1'b0;
        nxt();

        // ---------------- word load paused in cycle 3 ----------------
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h2000; data_len = 2'b10;
        wr_seen = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            rdy_in = (c != 3);
            smp();
            if (mem_wr) wr_seen = 1'b1;
            if (c == 4) chk("pause_reissue_addr", mem_a, 32'h2001);
            if (c == 6) chk("pause_no_early_ack", {31'd0, data_ack}, 32'h0);
            if (c == 8) begin
                chk("pause_ack_c8", {31'd0, data_ack}, 32'h1);
                chk("pause_word", data_rdata, 32'h8012_34FF);
            end
            nxt();
        end
        rdy_in = 1'b1; data_req = 1'b0;
        chk("pause_no_write", {31'd0, wr_seen}, 32'h0);
        nxt();

        // ---------------- flush during fetch ----------------
        inst_req = 1'b1; inst_addr = 32'h100; ack_seen = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            if (c == 2) begin
                data_req = 1'b1; data_we = 1'b0; data_addr = 32'h2000; data_len = 2'b00;
            end
            inst_flush = (c == 3);
            if (c >= 4) inst_req = 1'b0;
            smp();
            if (inst_ack) ack_seen = 1'b1;
            if (c == 4) chk("flush_idle_bus_c4", mem_a, 32'h0);
            if (c == 5) chk("flush_data_addr_c5", mem_a, 32'h2000);
            if (c == 7) begin
                chk("flush_data_ack_c7", {31'd0, data_ack}, 32'h1);
                chk("flush_data_byte", data_rdata, 32'h0000_00FF);
            end
            nxt();
            if (c == 7) data_req = 1'b0;
        end
        chk("flush_no_inst_ack", {31'd0, ack_seen}, 32'h0);
        nxt();

        // ---------------- starvation limit ordering ----------------
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (cnt == LIMIT) begin exp_ord[i] = 1; cnt = 0; end
            else begin exp_ord[i] = 0; cnt++; end
        end
        inst_req = 1'b1; inst_addr = 32'h100;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h2000; data_len = 2'b00;
        ng = 0;
        for (int c = 0; c < 100 && ng < 6; c++) begin
            smp();
            if (data_ack) begin got[ng] = 0; ng++; end
            else if (inst_ack) begin got[ng] = 1; ng++; end
            nxt();
        end
        inst_req = 1'b0; data_req = 1'b0;
        nxt(); nxt();
        chk("starve_grants_seen", ng, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("starve_grant_%0d_is_inst", i), got[i], exp_ord[i]);

        // ---------------- reset in the middle of a store ----------------
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h6000; data_len = 2'b10;
        data_wdata = 32'h1122_3344;
        nxt();
        nxt();
        smp();
        chk("rstmid_writing", {31'd0, mem_wr}, 32'h1);
        #2 rst_in_n = 1'b0;
        #1;
        chk("rstmid_mem_wr", {31'd0, mem_wr}, 32'h0);
        chk("rstmid_mem_a", mem_a, 32'h0);
        chk("rstmid_mem_dout", {24'd0, mem_dout}, 32'h0);
        chk("rstmid_acks", {30'd0, inst_ack, data_ack}, 32'h0);
        chk("rstmid_inst_data", inst_data, 32'h0);
        chk("rstmid_data_rdata", data_rdata, 32'h0);
        data_req = 1'b0; data_we = 1'b0;
        nxt();
        rst_in_n = 1'b1;
        nxt();

        // ---------------- random transactions vs. byte-level model ----------------
        for (int t = 0; t < 40; t++) begin
            kind  = $urandom_range(0, 2);
            addr  = 32'h5000 + 32'($urandom_range(0, 63));
            len   = 2'($urandom_range(0, 3));
            wdata = $urandom;
            rnd   = 1'($urandom_range(0, 1));
            n     = nbytes(kind, len);
            expd  = 32'd0;
            if (kind == 2) begin
                for (int k = 0; k < n; k++) ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
            end else begin
                for (int k = 0; k < n; k++) expd = expd | (32'(rd_ref(addr + 32'(k))) << (8 * k));
            end
            run_txn(kind, addr, len, wdata, rnd, lat, rdata, wr_bad, stalled);
            chk($sformatf("rnd%0d_completed", t), {31'd0, lat >= 0}, 32'h1);
            if (!stalled) chk($sformatf("rnd%0d_latency", t), lat, (kind == 2) ? n + 1 : n + 2);
            if (kind != 2) begin
                chk($sformatf("rnd%0d_data", t), rdata, expd);
                chk($sformatf("rnd%0d_no_write", t), {31'd0, wr_bad}, 32'h0);
            end
        end
        for (int a = 32'h5000; a < 32'h5043; a++) begin
            chk($sformatf("mem_0x%08h", a), {24'd0, rd_mem(32'(a))}, {24'd0, rd_ref(32'(a))});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
